// File: rtl/ayatsuki_irq_ctrl.sv
// ---------------------------------------------------------------------------
// ayatsuki_irq_ctrl
//   Interrupt controller on the far side of the core's interrupt handshake.
//   External sources are synchronised and latched as pending. Each line is
//   either edge- or level-sensitive. Pending lines are masked, and the
//   lowest-index survivor is presented to the core as a one-hot request.
//   The request is held until the core echoes it back exactly.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset
//   irq_src_i       raw interrupt sources (asynchronous to clk)
//   irq_req_o       registered one-hot request to the core
//   irq_response_i  one-hot acknowledge from the core
//   cfg_w_enable_i  register write strobe
//   cfg_r_enable_i  register read strobe
//   cfg_addr_i      register index: 0 MASK, 1 EDGE, 2 PENDING (W1C), 3 ACTIVE
//   cfg_w_data_i    write data (bits above IRQ_W ignored)
//   cfg_r_data_o    read data, registered one cycle after the read strobe
// ---------------------------------------------------------------------------
module ayatsuki_irq_ctrl #(
    parameter int IRQ_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq_src_i,
    output logic [IRQ_W-1:0] irq_req_o,
    input  logic [IRQ_W-1:0] irq_response_i,
    input  logic             cfg_w_enable_i,
    input  logic             cfg_r_enable_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [31:0]      cfg_w_data_i,
    output logic [31:0]      cfg_r_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][IRQ_W-1:0] sync_q;
    logic [IRQ_W-1:0] sync_prev_q;
    logic [IRQ_W-1:0] synced_s;
    logic [IRQ_W-1:0] mask_q;
    logic [IRQ_W-1:0] edge_q;
    logic [IRQ_W-1:0] pending_q, pending_d;
    logic [IRQ_W-1:0] active_q, active_d;
    logic [IRQ_W-1:0] req_q, req_d;
    logic [IRQ_W-1:0] cand_s;
    logic [IRQ_W-1:0] winner_s;
    logic [IRQ_W-1:0] w1c_s;
    logic [IRQ_W-1:0] ack_clr_s;
    logic             resp_match_s;
    logic [31:0]      rdata_q, rdata_d;
    logic             unused_wdata_s;

    // One-hot of the lowest set bit; zero when nothing is set.
    function automatic logic [IRQ_W-1:0] lowest_onehot(input logic [IRQ_W-1:0] v);
        logic [IRQ_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < IRQ_W; i++) begin
            if (!found && v[i]) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Zero-extend a line vector onto the 32-bit register bus.
    function automatic logic [31:0] zext(input logic [IRQ_W-1:0] v);
        logic [31:0] r;
        r          = '0;
        r[IRQ_W-1:0] = v;
        return r;
    endfunction

    assign synced_s       = sync_q[SYNC_STAGES-1];
    assign unused_wdata_s = ^cfg_w_data_i;
    assign irq_req_o      = req_q;
    assign cfg_r_data_o   = rdata_q;
    assign cand_s         = pending_q & mask_q;
    assign winner_s       = lowest_onehot(cand_s);

    // Source synchroniser chain plus the previous synced value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            sync_prev_q <= '0;
        end else begin
            sync_q[0] <= irq_src_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_prev_q <= synced_s;
        end
    end

    // MASK and EDGE configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            edge_q <= '0;
        end else if (cfg_w_enable_i && (cfg_addr_i == 2'd0)) begin
            mask_q <= cfg_w_data_i[IRQ_W-1:0];
        end else if (cfg_w_enable_i && (cfg_addr_i == 2'd1)) begin
            edge_q <= cfg_w_data_i[IRQ_W-1:0];
        end
    end

    // Clear sources for edge-mode pending bits: software W1C and a matching core ack.
    always_comb begin
        w1c_s        = '0;
        resp_match_s = (state_q == ST_REQ) && (irq_response_i == req_q);
        if (cfg_w_enable_i && (cfg_addr_i == 2'd2)) begin
            w1c_s = cfg_w_data_i[IRQ_W-1:0];
        end else begin
            w1c_s = '0;
        end
        if (resp_match_s) begin
            ack_clr_s = req_q;
        end else begin
            ack_clr_s = '0;
        end
    end

    // Pending next state: edge lines latch rising edges (set beats clear), level lines track the input.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < IRQ_W; i++) begin
            if (edge_q[i]) begin
                pending_d[i] = (synced_s[i] & ~sync_prev_q[i])
                             | (pending_q[i] & ~(w1c_s[i] | ack_clr_s[i]));
            end else begin
                pending_d[i] = synced_s[i];
            end
        end
    end

    // Handshake FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_s != '0) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (resp_match_s) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake FSM outputs: the request is frozen while in REQ regardless of mask or pending changes.
    always_comb begin
        req_d    = req_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_s != '0) begin
                    req_d    = winner_s;
                    active_d = winner_s;
                end else begin
                    req_d    = '0;
                    active_d = active_q;
                end
            end
            ST_REQ: begin
                if (resp_match_s) begin
                    req_d = '0;
                end else begin
                    req_d = req_q;
                end
            end
            ST_ACK: begin
                req_d    = '0;
                active_d = '0;
            end
            default: begin
                req_d    = '0;
                active_d = '0;
            end
        endcase
    end

    // Register read mux; the read data holds when no read is strobed.
    always_comb begin
        rdata_d = rdata_q;
        if (cfg_r_enable_i) begin
            case (cfg_addr_i)
                2'd0:    rdata_d = zext(mask_q);
                2'd1:    rdata_d = zext(edge_q);
                2'd2:    rdata_d = zext(pending_q);
                2'd3:    rdata_d = zext(active_q);
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, pending, request, active and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            req_q     <= '0;
            active_q  <= '0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            active_q  <= active_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ayatsuki_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ayatsuki_irq_ctrl
//   Directed-vector bench for ayatsuki_irq_ctrl (IRQ_W=8, SYNC_STAGES=2).
//   Inputs change 1 ns after the rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_ayatsuki_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_src_i;
    logic [7:0]  irq_req_o;
    logic [7:0]  irq_response_i;
    logic        cfg_w_enable_i;
    logic        cfg_r_enable_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_w_data_i;
    logic [31:0] cfg_r_data_o;

    int          n_checks;
    int          n_fail;
    logic [31:0] rv;

    ayatsuki_irq_ctrl #(
        .IRQ_W       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src_i      (irq_src_i),
        .irq_req_o      (irq_req_o),
        .irq_response_i (irq_response_i),
        .cfg_w_enable_i (cfg_w_enable_i),
        .cfg_r_enable_i (cfg_r_enable_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_w_data_i   (cfg_w_data_i),
        .cfg_r_data_o   (cfg_r_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        cfg_w_enable_i = 1'b1;
        cfg_addr_i     = addr;
        cfg_w_data_i   = data;
        tick();
        cfg_w_enable_i = 1'b0;
        cfg_w_data_i   = 32'd0;
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        cfg_r_enable_i = 1'b1;
        cfg_addr_i     = addr;
        tick();
        cfg_r_enable_i = 1'b0;
        data           = cfg_r_data_o;
    endtask

    // One-cycle source pulse captured at the next edge (edge k).
    task automatic pulse(input logic [7:0] v);
        irq_src_i = v;
        tick();
        irq_src_i = 8'h00;
    endtask

    task automatic ack(input logic [7:0] v);
        irq_response_i = v;
        tick();
        irq_response_i = 8'h00;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        irq_src_i      = 8'h00;
        irq_response_i = 8'h00;
        cfg_w_enable_i = 1'b0;
        cfg_r_enable_i = 1'b0;
        cfg_addr_i     = 2'd0;
        cfg_w_data_i   = 32'd0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_req", {24'd0, irq_req_o}, 32'h0);
        check("rst_rdata", cfg_r_data_o, 32'h0);
        rst = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], rv);
            check("rst_reg", rv, 32'h0);
        end

        // ---- edge path: pulse on src[3] ----
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        pulse(8'h08);                 // edge k
        tick();                       // k+1
        tick();                       // k+2
        check("edge_lat_k2", {24'd0, irq_req_o}, 32'h00);
        tick();                       // k+3
        check("edge_req", {24'd0, irq_req_o}, 32'h08);
        rd(2'd3, rv);
        check("edge_active", rv, 32'h08);
        rd(2'd2, rv);
        check("edge_pend", rv, 32'h08);
        ack(8'h08);                   // accepting edge
        check("edge_ack_req", {24'd0, irq_req_o}, 32'h00);
        rd(2'd2, rv);
        check("edge_pend_clr", rv, 32'h00);
        rd(2'd3, rv);
        check("edge_active_clr", rv, 32'h00);

        // ---- priority: src[5] and src[2] together ----
        pulse(8'h24);
        tick();
        tick();
        tick();
        check("prio_first", {24'd0, irq_req_o}, 32'h04);
        ack(8'h04);
        check("prio_gap1", {24'd0, irq_req_o}, 32'h00);
        tick();
        check("prio_gap2", {24'd0, irq_req_o}, 32'h00);
        tick();
        check("prio_second", {24'd0, irq_req_o}, 32'h20);
        ack(8'h20);
        tick();
        tick();
        check("prio_idle", {24'd0, irq_req_o}, 32'h00);

        // ---- bad responses are ignored ----
        pulse(8'h04);
        tick();
        tick();
        tick();
        check("bad_req", {24'd0, irq_req_o}, 32'h04);
        ack(8'h01);
        check("bad_resp_01", {24'd0, irq_req_o}, 32'h04);
        ack(8'h06);
        check("bad_resp_06", {24'd0, irq_req_o}, 32'h04);
        ack(8'h00);
        check("bad_resp_00", {24'd0, irq_req_o}, 32'h04);
        ack(8'h04);
        check("bad_good_ack", {24'd0, irq_req_o}, 32'h00);
        tick();
        tick();

        // ---- mask: pending without request, then unmask ----
        wr(2'd0, 32'h00);
        pulse(8'h02);
        tick();
        tick();
        tick();
        check("mask_noreq", {24'd0, irq_req_o}, 32'h00);
        rd(2'd2, rv);
        check("mask_pend", rv, 32'h02);
        wr(2'd0, 32'h02);             // write edge W
        check("unmask_w", {24'd0, irq_req_o}, 32'h00);
        tick();                       // W+1
        check("unmask_req", {24'd0, irq_req_o}, 32'h02);
        ack(8'h02);
        tick();
        tick();

        // ---- W1C before unmask: no request ----
        wr(2'd0, 32'h00);
        pulse(8'h02);
        tick();
        tick();
        tick();
        rd(2'd2, rv);
        check("w1c_pend_set", rv, 32'h02);
        wr(2'd2, 32'h02);
        rd(2'd2, rv);
        check("w1c_pend_clr", rv, 32'h00);
        wr(2'd0, 32'h02);
        tick();
        tick();
        check("w1c_noreq", {24'd0, irq_req_o}, 32'h00);

        // ---- read and write same address in one cycle: old value ----
        cfg_w_enable_i = 1'b1;
        cfg_r_enable_i = 1'b1;
        cfg_addr_i     = 2'd0;
        cfg_w_data_i   = 32'hFFFF_FFFF;
        tick();
        cfg_w_enable_i = 1'b0;
        cfg_r_enable_i = 1'b0;
        cfg_w_data_i   = 32'd0;
        check("rw_old", cfg_r_data_o, 32'h02);
        rd(2'd0, rv);
        check("rw_new", rv, 32'hFF);

        // ---- level mode ----
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h01);
        irq_src_i = 8'h01;
        tick();                       // k
        tick();
        tick();
        tick();                       // k+3
        check("lvl_req", {24'd0, irq_req_o}, 32'h01);
        ack(8'h01);                   // E
        check("lvl_gap1", {24'd0, irq_req_o}, 32'h00);
        tick();
        check("lvl_gap2", {24'd0, irq_req_o}, 32'h00);
        tick();
        check("lvl_rereq", {24'd0, irq_req_o}, 32'h01);
        ack(8'h01);                   // E
        irq_src_i = 8'h00;
        tick();                       // E+1
        tick();                       // E+2
        check("lvl_rereq2", {24'd0, irq_req_o}, 32'h01);
        rd(2'd2, rv);                 // E+3 samples pending before it drops
        check("lvl_pend_hi", rv, 32'h01);
        rd(2'd2, rv);
        check("lvl_pend_lo", rv, 32'h00);
        check("lvl_req_held", {24'd0, irq_req_o}, 32'h01);

        // ---- asynchronous reset mid-cycle while in REQ ----
        irq_src_i = 8'hFF;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_req", {24'd0, irq_req_o}, 32'h00);
        irq_src_i = 8'h00;
        tick();
        check("async_rst_hold", {24'd0, irq_req_o}, 32'h00);
        rst = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], rv);
            check("rst2_reg", rv, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
